axi4_burst_slave: RTL and testbench

//  AXI4 slave to Red Pitaya simple system-bus bridge, successor to the single-beat bridge.

---
 rtl/axi4_burst_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axi4_burst_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_slave.sv
// axi4_burst_slave
//   Bridges an AXI4 slave port onto the Red Pitaya simple system bus. It handles
//   INCR and FIXED bursts of up to 256 beats, byte strobes on writes, a
//   per-beat bus timeout, and selectable AW/AR arbitration.
// Ports
//   ACLK, ARESET            clock, asynchronous active-high reset
//   AW*/W*/B*, AR*/R*       AXI4 slave channels (ID width IW, data width DW)
//   bus_addr/wdata/sel      registered system-bus request; stable until ack or timeout
//   bus_wen/bus_ren         one-cycle access strobes
//   bus_rdata/ack/err       system-bus response; err only counts together with ack
module axi4_burst_slave #(
    parameter int DW        = 64,
    parameter int AW        = 32,
    parameter int IW        = 12,
    parameter int TO_CYCLES = 32,
    parameter int ARB_MODE  = 0,
    localparam int SW       = DW / 8,
    localparam int LSZ      = $clog2(SW)
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic [IW-1:0] AWID,
    input  logic [AW-1:0] AWADDR,
    input  logic [7:0]    AWLEN,
    input  logic [2:0]    AWSIZE,
    input  logic [1:0]    AWBURST,
    input  logic          AWVALID,
    output logic          AWREADY,
    input  logic [DW-1:0] WDATA,
    input  logic [SW-1:0] WSTRB,
    input  logic          WLAST,
    input  logic          WVALID,
    output logic          WREADY,
    output logic [IW-1:0] BID,
    output logic [1:0]    BRESP,
    output logic          BVALID,
    input  logic          BREADY,
    input  logic [IW-1:0] ARID,
    input  logic [AW-1:0] ARADDR,
    input  logic [7:0]    ARLEN,
    input  logic [2:0]    ARSIZE,
    input  logic [1:0]    ARBURST,
    input  logic          ARVALID,
    output logic          ARREADY,
    output logic [IW-1:0] RID,
    output logic [DW-1:0] RDATA,
    output logic [1:0]    RRESP,
    output logic          RLAST,
    output logic          RVALID,
    input  logic          RREADY,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [SW-1:0] bus_sel,
    output logic          bus_wen,
    output logic          bus_ren,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    input  logic          bus_err
);

    localparam int TW = $clog2(TO_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WBEAT = 3'd1;
    localparam logic [2:0] S_WACK  = 3'd2;
    localparam logic [2:0] S_BRESP = 3'd3;
    localparam logic [2:0] S_RACK  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          prio_w_q, prio_w_d;       // RR: 1 = write wins the next tie
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          incr_q, incr_d;
    logic [7:0]    cnt_q, cnt_d;             // beats remaining after the current one
    logic          err_burst_q, err_burst_d;
    logic          any_err_q, any_err_d;
    logic          wlast_err_q, wlast_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          wen_q, wen_d;
    logic          ren_q, ren_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rlast_q, rlast_d;

    logic          grant_w, grant_r;
    logic          beat_done, beat_err;
    logic [AW-1:0] next_addr;

    // Unsupported burst types or sizes wider than the data bus are not
    // forwarded to the bus at all; every beat just reports SLVERR.
    function automatic logic bad_burst(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size > 3'(LSZ));
    endfunction

    // Tie-break only matters when both channels are valid in the same cycle.
    always_comb begin
        grant_w = AWVALID && (!ARVALID || (ARB_MODE == 0) || prio_w_q);
        grant_r = ARVALID && !grant_w;
    end

    // Readies are masked by reset so nothing can handshake while it is held.
    assign AWREADY   = !ARESET && (state_q == S_IDLE) && grant_w;
    assign ARREADY   = !ARESET && (state_q == S_IDLE) && grant_r;
    assign WREADY    = (state_q == S_WBEAT);
    assign BVALID    = (state_q == S_BRESP);
    assign BRESP     = any_err_q ? 2'b10 : 2'b00;
    assign BID       = id_q;
    assign RVALID    = (state_q == S_RDATA);
    assign RID       = id_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RLAST     = rlast_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_sel   = sel_q;
    assign bus_wen   = wen_q;
    assign bus_ren   = ren_q;

    assign next_addr = incr_q ? addr_q + (AW'(1) << size_q) : addr_q;

    // Beat completion while waiting in WACK/RACK. Error bursts finish at once.
    // Otherwise an ack finishes the beat. If no ack arrives, the timer ends the
    // beat once TO_CYCLES cycles have passed after the strobe.
    always_comb begin
        beat_done = 1'b0;
        beat_err  = 1'b0;
        if (err_burst_q) begin
            beat_done = 1'b1;
            beat_err  = 1'b1;
        end else if (bus_ack) begin
            beat_done = 1'b1;
            beat_err  = bus_err;
        end else if (to_cnt_q == TW'(TO_CYCLES)) begin
            beat_done = 1'b1;
            beat_err  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_w_d    = prio_w_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        incr_d      = incr_q;
        cnt_d       = cnt_q;
        err_burst_d = err_burst_q;
        any_err_d   = any_err_q;
        wlast_err_d = wlast_err_q;
        to_cnt_d    = to_cnt_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;

        case (state_q)
            S_IDLE: begin
                if (grant_w) begin
                    id_d        = AWID;
                    addr_d      = AWADDR;
                    size_d      = AWSIZE;
                    incr_d      = (AWBURST == 2'b01);
                    cnt_d       = AWLEN;
                    err_burst_d = bad_burst(AWBURST, AWSIZE);
                    any_err_d   = 1'b0;
                    prio_w_d    = 1'b0;
                    state_d     = S_WBEAT;
                end else if (grant_r) begin
                    id_d        = ARID;
                    addr_d      = ARADDR;
                    size_d      = ARSIZE;
                    incr_d      = (ARBURST == 2'b01);
                    cnt_d       = ARLEN;
                    err_burst_d = bad_burst(ARBURST, ARSIZE);
                    ren_d       = !bad_burst(ARBURST, ARSIZE);
                    sel_d       = bad_burst(ARBURST, ARSIZE) ? '0 : '1;
                    to_cnt_d    = '0;
                    prio_w_d    = 1'b1;
                    state_d     = S_RACK;
                end
            end
            S_WBEAT: begin
                if (WVALID) begin
                    wdata_d     = WDATA;
                    sel_d       = WSTRB;
                    // WLAST is only checked for consistency; AWLEN sets the beat count.
                    wlast_err_d = (WLAST != (cnt_q == 8'd0));
                    wen_d       = !err_burst_q;
                    to_cnt_d    = '0;
                    state_d     = S_WACK;
                end
            end
            S_WACK: begin
                if (beat_done) begin
                    any_err_d = any_err_q | beat_err | wlast_err_q;
                    if (cnt_q == 8'd0) begin
                        state_d = S_BRESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr;
                        state_d = S_WBEAT;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_BRESP: begin
                if (BREADY) state_d = S_IDLE;
            end
            S_RACK: begin
                if (beat_done) begin
                    rdata_d = beat_err ? '0 : bus_rdata;
                    rresp_d = beat_err ? 2'b10 : 2'b00;
                    rlast_d = (cnt_q == 8'd0);
                    state_d = S_RDATA;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_RDATA: begin
                if (RREADY) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d    = cnt_q - 8'd1;
                        addr_d   = next_addr;
                        ren_d    = !err_burst_q;
                        to_cnt_d = '0;
                        state_d  = S_RACK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            prio_w_q    <= 1'b1;
            id_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            incr_q      <= 1'b0;
            cnt_q       <= '0;
            err_burst_q <= 1'b0;
            any_err_q   <= 1'b0;
            wlast_err_q <= 1'b0;
            to_cnt_q    <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_w_q    <= prio_w_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            incr_q      <= incr_d;
            cnt_q       <= cnt_d;
            err_burst_q <= err_burst_d;
            any_err_q   <= any_err_d;
            wlast_err_q <= wlast_err_d;
            to_cnt_q    <= to_cnt_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst_slave.sv
// tb_axi4_burst_slave
//   Directed bench for axi4_burst_slave. It uses two instances:
//   u_dut (write priority, TO_CYCLES=32) runs the functional sequences, and
//   u_rr (round-robin) runs on its own with a self-acking bus.
//   Inputs are driven 1ns after posedge ACLK, and outputs are sampled on negedge.
module tb_axi4_burst_slave;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 12;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [IW-1:0] AWID = '0, ARID = '0, BID, RID;
    logic [AW-1:0] AWADDR = '0, ARADDR = '0, bus_addr;
    logic [7:0]    AWLEN = '0, ARLEN = '0;
    logic [2:0]    AWSIZE = '0, ARSIZE = '0;
    logic [1:0]    AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic          AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
    logic          BREADY = 1'b0, RREADY = 1'b0;
    logic          AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST;
    logic [DW-1:0] WDATA = '0, RDATA, bus_wdata, bus_rdata;
    logic [SW-1:0] WSTRB = '0, bus_sel;
    logic          bus_wen, bus_ren, bus_ack, bus_err;

    // bus model: combinational ack on the strobe, optional error on one write beat
    logic ack_en = 1'b1, err_on = 1'b0, late_ack = 1'b0;
    int   err_beat = -1;
    int   wen_idx = 0;
    assign bus_ack   = (ack_en & (bus_wen | bus_ren)) | late_ack;
    assign bus_err   = bus_ack & err_on & (wen_idx == err_beat);
    assign bus_rdata = {32'hA5A5_0000, bus_addr};
    always @(posedge ACLK) if (bus_wen) wen_idx <= wen_idx + 1;

    axi4_burst_slave #(.DW(DW), .AW(AW), .IW(IW), .TO_CYCLES(32), .ARB_MODE(0)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
    );

    // round-robin instance: always ready on W/B/R, single-beat requests
    logic          rr_go = 1'b0;
    logic          r2_awready, r2_arready, r2_wready, r2_bvalid, r2_rvalid, r2_rlast;
    logic [IW-1:0] r2_bid, r2_rid;
    logic [1:0]    r2_bresp, r2_rresp;
    logic [DW-1:0] r2_rdata, r2_wdata;
    logic [AW-1:0] r2_addr;
    logic [SW-1:0] r2_sel;
    logic          r2_wen, r2_ren, r2_ack;
    assign r2_ack = r2_wen | r2_ren;

    axi4_burst_slave #(.DW(DW), .AW(AW), .IW(IW), .TO_CYCLES(32), .ARB_MODE(1)) u_rr (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(12'h001), .AWADDR(32'h10), .AWLEN(8'd0), .AWSIZE(3'd3), .AWBURST(2'b01),
        .AWVALID(rr_go), .AWREADY(r2_awready),
        .WDATA(64'h1), .WSTRB(8'hFF), .WLAST(1'b1), .WVALID(1'b1), .WREADY(r2_wready),
        .BID(r2_bid), .BRESP(r2_bresp), .BVALID(r2_bvalid), .BREADY(1'b1),
        .ARID(12'h002), .ARADDR(32'h20), .ARLEN(8'd0), .ARSIZE(3'd3), .ARBURST(2'b01),
        .ARVALID(rr_go), .ARREADY(r2_arready),
        .RID(r2_rid), .RDATA(r2_rdata), .RRESP(r2_rresp), .RLAST(r2_rlast), .RVALID(r2_rvalid),
        .RREADY(1'b1),
        .bus_addr(r2_addr), .bus_wdata(r2_wdata), .bus_sel(r2_sel),
        .bus_wen(r2_wen), .bus_ren(r2_ren),
        .bus_rdata(64'h0), .bus_ack(r2_ack), .bus_err(1'b0)
    );

    always #5 ACLK = ~ACLK;

    // negedge monitors
    int            wen_cnt = 0, ren_cnt = 0, b_cnt = 0;
    logic [AW-1:0] wen_addr[$], ren_addr[$];
    logic [SW-1:0] last_sel = '0;
    logic [DW-1:0] last_wdata = '0;
    bit            gnt_log[$], rr_log[$];   // 1 = AW granted, 0 = AR granted
    always @(negedge ACLK) begin
        if (bus_wen) begin
            wen_cnt <= wen_cnt + 1;
            wen_addr.push_back(bus_addr);
            last_sel   <= bus_sel;
            last_wdata <= bus_wdata;
        end
        if (bus_ren) begin
            ren_cnt <= ren_cnt + 1;
            ren_addr.push_back(bus_addr);
        end
        if (BVALID && BREADY) b_cnt <= b_cnt + 1;
        if (AWVALID && AWREADY) gnt_log.push_back(1'b1);
        if (ARVALID && ARREADY) gnt_log.push_back(1'b0);
        if (rr_go && r2_awready) rr_log.push_back(1'b1);
        if (rr_go && r2_arready) rr_log.push_back(1'b0);
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n = 0;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bu; AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("aw_wait", 64'(n < 50), 64'd1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        int n = 0;
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bu; ARVALID = 1'b1;
        @(negedge ACLK);
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("ar_wait", 64'(n < 50), 64'd1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("w_wait", 64'(n < 50), 64'd1);
        tick();
        WVALID = 1'b0;
    endtask

    task automatic b_wait(output logic [1:0] rs, output logic [IW-1:0] id);
        int n = 0;
        BREADY = 1'b1;
        @(negedge ACLK);
        while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
        chk("b_wait", 64'(n < 100), 64'd1);
        rs = BRESP; id = BID;
        tick();
        BREADY = 1'b0;
    endtask

    // Waits for RVALID, keeps RREADY low for 'hold' cycles while checking that R
    // stays stable, and then completes the handshake.
    task automatic r_get(input int hold, output logic [DW-1:0] d, output logic [1:0] rs,
                         output logic l, output logic [IW-1:0] id);
        int n = 0;
        RREADY = 1'b0;
        @(negedge ACLK);
        while (!RVALID && n < 100) begin @(negedge ACLK); n++; end
        chk("r_wait", 64'(n < 100), 64'd1);
        d = RDATA; rs = RRESP; l = RLAST; id = RID;
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge ACLK);
            chk("r_hold_valid", 64'(RVALID), 64'd1);
            chk("r_hold_data", RDATA, d);
            chk("r_hold_last", 64'(RLAST), 64'(l));
            chk("r_hold_resp", 64'(RRESP), 64'(rs));
        end
        tick();
        RREADY = 1'b1;
        @(negedge ACLK);
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]    rs;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic          l;
        int            w0, r0, b0, g0, n, nr;

        // reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_wen_ren", 64'({bus_wen, bus_ren}), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_sel", 64'(bus_sel), 64'd0);
        tick();
        ARESET = 1'b0;
        tick();
        @(negedge ACLK);
        chk("idle_readies", 64'({AWREADY, ARREADY}), 64'd0);
        tick();

        // 1: single write, ack in the strobe cycle
        w0 = wen_cnt;
        aw_send(12'h5A5, 32'h40, 8'd0, 3'd2, 2'b01);
        w_send(64'h1122_3344, 8'h0F, 1'b1);
        b_wait(rs, id);
        chk("t1_wen_cnt", 64'(wen_cnt - w0), 64'd1);
        chk("t1_wen_addr", 64'(wen_addr[w0]), 64'h40);
        chk("t1_bus_sel", 64'(last_sel), 64'h0F);
        chk("t1_bus_wdata", last_wdata, 64'h1122_3344);
        chk("t1_bresp", 64'(rs), 64'd0);
        chk("t1_bid", 64'(id), 64'h5A5);

        // 2: INCR read of 4 beats, RREADY held low for 2 cycles on every beat
        r0 = ren_cnt;
        ar_send(12'h0C3, 32'h100, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            r_get(2, d, rs, l, id);
            chk("t2_rdata", d, {32'hA5A5_0000, 32'h100 + 32'(4 * i)});
            chk("t2_rresp", 64'(rs), 64'd0);
            chk("t2_rlast", 64'(l), 64'(i == 3));
            chk("t2_rid", 64'(id), 64'h0C3);
        end
        chk("t2_ren_cnt", 64'(ren_cnt - r0), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t2_ren_addr", 64'(ren_addr[r0 + i]), 64'h100 + 64'(4 * i));

        // 3: FIXED write of 3 beats with a bus error on beat 1
        w0 = wen_cnt; b0 = b_cnt;
        err_on = 1'b1; err_beat = wen_idx + 1;
        aw_send(12'h003, 32'h20, 8'd2, 3'd3, 2'b00);
        for (int i = 0; i < 3; i++) w_send(64'(i + 1), 8'hFF, 1'(i == 2));
        b_wait(rs, id);
        err_on = 1'b0;
        repeat (4) tick();
        chk("t3_wen_cnt", 64'(wen_cnt - w0), 64'd3);
        for (int i = 0; i < 3; i++) chk("t3_wen_addr", 64'(wen_addr[w0 + i]), 64'h20);
        chk("t3_bresp", 64'(rs), 64'h2);
        chk("t3_b_count", 64'(b_cnt - b0), 64'd1);
        chk("t3_bvalid_low", 64'(BVALID), 64'd0);

        // 4: no ack -> timeout 33 cycles after ren, late ack at cycle 40 ignored
        ack_en = 1'b0; r0 = ren_cnt;
        ar_send(12'h007, 32'h200, 8'd0, 3'd3, 2'b01);
        n = 0;
        @(negedge ACLK);
        while (!bus_ren && n < 10) begin @(negedge ACLK); n++; end
        chk("t4_ren_seen", 64'(bus_ren), 64'd1);
        n = 0;
        while (!RVALID && n < 100) begin @(negedge ACLK); n++; end
        chk("t4_latency", 64'(n), 64'd33);
        while (n < 39) begin @(negedge ACLK); n++; end
        tick();
        late_ack = 1'b1;
        @(negedge ACLK);
        tick();
        late_ack = 1'b0;
        @(negedge ACLK);
        chk("t4_rvalid_held", 64'(RVALID), 64'd1);
        tick();
        r_get(0, d, rs, l, id);
        chk("t4_rresp", 64'(rs), 64'h2);
        chk("t4_rdata", d, 64'd0);
        chk("t4_rlast", 64'(l), 64'd1);
        ack_en = 1'b1;
        repeat (3) tick();
        chk("t4_ren_cnt", 64'(ren_cnt - r0), 64'd1);
        chk("t4_idle", 64'(RVALID), 64'd0);

        // 5: WRAP write and oversize read -> no bus access, SLVERR on every beat
        w0 = wen_cnt; r0 = ren_cnt;
        aw_send(12'h009, 32'h80, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) w_send(64'hAB, 8'hFF, 1'(i == 3));
        b_wait(rs, id);
        chk("t5_wrap_bresp", 64'(rs), 64'h2);
        chk("t5_wrap_no_wen", 64'(wen_cnt - w0), 64'd0);
        ar_send(12'h00A, 32'h300, 8'd1, 3'd4, 2'b01);
        for (int i = 0; i < 2; i++) begin
            r_get(0, d, rs, l, id);
            chk("t5_size_rresp", 64'(rs), 64'h2);
            chk("t5_size_rdata", d, 64'd0);
            chk("t5_size_rlast", 64'(l), 64'(i == 1));
        end
        chk("t5_size_no_ren", 64'(ren_cnt - r0), 64'd0);

        // 6a/6b: both requests held; u_dut always grants writes, u_rr alternates
        g0 = gnt_log.size();
        AWID = 12'h011; AWADDR = 32'h0; AWLEN = 8'd0; AWSIZE = 3'd3; AWBURST = 2'b01;
        ARID = 12'h012; ARADDR = 32'h8; ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01;
        WDATA = 64'h5; WSTRB = 8'hFF; WLAST = 1'b1; WVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b1; ARVALID = 1'b1; rr_go = 1'b1;
        repeat (40) tick();
        AWVALID = 1'b0; ARVALID = 1'b0; rr_go = 1'b0;
        repeat (10) tick();
        WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
        chk("t6_wp_count", 64'(gnt_log.size() - g0 >= 3), 64'd1);
        nr = 0;
        for (int i = g0; i < gnt_log.size(); i++) if (!gnt_log[i]) nr++;
        chk("t6_wp_no_read", 64'(nr), 64'd0);
        for (int i = 0; i < 3 && g0 + i < gnt_log.size(); i++)
            chk("t6_wp_order", 64'(gnt_log[g0 + i]), 64'd1);
        chk("t6_rr_count", 64'(rr_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < rr_log.size(); i++)
            chk("t6_rr_order", 64'(rr_log[i]), 64'((i % 2) == 0));
        chk("t6_rr_resp", 64'({r2_bresp, r2_rresp}), 64'd0);

        // 6c: reset in the middle of a burst, then a clean write
        aw_send(12'h001, 32'h60, 8'd3, 3'd3, 2'b01);
        w_send(64'h77, 8'hFF, 1'b0);
        ARESET = 1'b1; AWVALID = 1'b1; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("t6_rst_readies", 64'({AWREADY, ARREADY, WREADY}), 64'd0);
        chk("t6_rst_valids", 64'({BVALID, RVALID}), 64'd0);
        chk("t6_rst_pulses", 64'({bus_wen, bus_ren}), 64'd0);
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        tick();
        ARESET = 1'b0;
        tick();
        w0 = wen_cnt;
        aw_send(12'h077, 32'h48, 8'd0, 3'd2, 2'b01);
        w_send(64'hDEAD_BEEF, 8'hF0, 1'b1);
        b_wait(rs, id);
        chk("t6_post_bresp", 64'(rs), 64'd0);
        chk("t6_post_bid", 64'(id), 64'h077);
        chk("t6_post_wen_cnt", 64'(wen_cnt - w0), 64'd1);
        chk("t6_post_addr", 64'(wen_addr[w0]), 64'h48);
        chk("t6_post_sel", 64'(last_sel), 64'hF0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
